button_frontend: RTL

Parametrised front end for all player inputs: synchronises `NUM_BTN` local push-buttons and `NUM_BTN` opponent data lines. Local buttons are debounced on a shared rate tick and edge-detected. Local events are priority-encoded to one-hot and held for one tick period, so local and opponent events reach the game FSM at the same rate. Sits between board pins / inter-board link and the Connect-4 game controller.

---
 rtl/connect4_input_pkg.sv | 14 +
 rtl/debounce_channel.sv | 72 +++++++
 rtl/button_frontend.sv | 78 +++++++
 3 files changed

// File: rtl/connect4_input_pkg.sv
// Shared definitions for the Connect-4 input path: channel indices and
// default sizing for the button front end.
package connect4_input_pkg;

    localparam int BTN_PUT   = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 2;

    localparam int DEF_NUM_BTN      = 3;
    localparam int DEF_TICK_W       = 3;
    localparam int DEF_DEB_TICKS    = 4;
    localparam int DEF_REPEAT_TICKS = 64;

endpackage

// File: rtl/debounce_channel.sv
// One local button: 2-FF synchroniser, tick-rate debouncer and press request.
// Auto-repeat requests are added when BUTTON_FRONTEND_AUTO_REPEAT_EN is defined.
module debounce_channel #(
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic req
);

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);

    logic [1:0]    sync_ff;
    logic          synced;
    logic          level;
    logic [DW-1:0] deb_cnt;
    logic          flip;
    logic          press;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) sync_ff <= '0;
        else      sync_ff <= {sync_ff[0], btn};
    end

    assign synced = sync_ff[1];
    // The last disagreeing tick flips the level instead of bumping the counter.
    assign flip  = tick && (synced != level) && (deb_cnt == DEB_LAST);
    assign press = flip && !level;

    always_ff @(posedge clk) begin
        if (!rst) begin
            level   <= 1'b0;
            deb_cnt <= '0;
        end else if (tick) begin
            if (synced == level) begin
                deb_cnt <= '0;
            end else if (flip) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

`ifdef BUTTON_FRONTEND_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_hit;

    assign rep_hit = tick && level && (rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !level) rep_cnt <= '0;
        else if (tick)      rep_cnt <= rep_hit ? '0 : rep_cnt + RW'(1);
    end

    assign req = press || rep_hit;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_TICKS > 0);
    assign req = press;
`endif

endmodule

// File: rtl/button_frontend.sv
// Player input front end: rate tick, opponent-line synchroniser, per-button
// debounce, priority arbitration and one-tick output hold.
// Optional auto-repeat: define BUTTON_FRONTEND_AUTO_REPEAT_EN.
module button_frontend
    import connect4_input_pkg::*;
#(
    parameter int NUM_BTN      = DEF_NUM_BTN,
    parameter int TICK_W       = DEF_TICK_W,
    parameter int DEB_TICKS    = DEF_DEB_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_BTN-1:0] opp_in,
    output logic [NUM_BTN-1:0] self_evt,
    output logic [NUM_BTN-1:0] opp_evt,
    output logic               tick,
    output logic               drop_evt
);

    logic [TICK_W-1:0]  tick_cnt;
    logic [NUM_BTN-1:0] opp_meta;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] win;

    always_ff @(posedge clk) begin
        if (!rst) tick_cnt <= '0;
        else      tick_cnt <= tick_cnt + TICK_W'(1);
    end

    assign tick = &tick_cnt;

    // Opponent lines are already clean; they only need synchronising.
    always_ff @(posedge clk) begin
        if (!rst) begin
            opp_meta <= '0;
            opp_evt  <= '0;
        end else begin
            opp_meta <= opp_in;
            opp_evt  <= opp_meta;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .tick(tick),
            .btn (btn_in[g]),
            .req (req[g])
        );
    end

    // NOTE: the default assignment first keeps this always_comb latch-free.
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (req[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

    // Requests only exist on a tick, so more than one set bit means a loser.
    assign drop_evt = |(req & (req - NUM_BTN'(1)));

    // Reloaded on every tick: a winner is held for exactly one tick period.
    always_ff @(posedge clk) begin
        if (!rst)      self_evt <= '0;
        else if (tick) self_evt <= win;
    end

endmodule
